// File: rtl/clk_div_cfg_ctrl.sv
// Configuration front-end for clk_div: accepts ratio/enable updates over valid/ready and
// lands them on a divided-period boundary so the divider never emits a runt or stretched pulse.
module clk_div_cfg_ctrl #(
    parameter int RATIO_W   = 3,
    parameter int DEF_RATIO = 2,
    parameter int MIN_RATIO = 1
) (
    input  logic               i_ref_clk,
    input  logic               i_rst,
    input  logic               i_cfg_valid,
    input  logic [RATIO_W-1:0] i_cfg_ratio,
    input  logic               i_cfg_en,
    output logic               o_cfg_ready,
    output logic [RATIO_W-1:0] o_div_ratio,
    output logic               o_clk_en,
    output logic               o_cfg_done,
    output logic               o_cfg_err,
    output logic               o_busy,
    output logic               o_period_tick
);

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_WAIT_BND = 2'd1;
    localparam logic [1:0] ST_APPLY    = 2'd2;

    logic [1:0]         state_reg, state_next;
    logic [RATIO_W-1:0] div_ratio_reg;
    logic               clk_en_reg;
    logic [RATIO_W-1:0] cnt_reg;
    logic [RATIO_W-1:0] pend_ratio_reg;
    logic               pend_en_reg;
    logic               done_reg, done_next;
    logic               err_reg, err_next;

    logic               accept;
    logic               req_illegal;
    logic               req_same;
    logic               tick_w;
    logic               load_cfg;
    logic [RATIO_W-1:0] load_ratio;
    logic               load_en;

    assign accept      = i_cfg_valid && (state_reg == ST_IDLE);
    assign req_illegal = i_cfg_ratio < RATIO_W'(MIN_RATIO);
    assign req_same    = (i_cfg_ratio == div_ratio_reg) && (i_cfg_en == clk_en_reg);
    // Ratio 1 makes the last count 0, so every cycle is a boundary and cnt never leaves 0.
    assign tick_w      = clk_en_reg && (cnt_reg == div_ratio_reg - RATIO_W'(1));

    always_comb begin
        state_next = state_reg;
        load_cfg   = 1'b0;
        load_ratio = div_ratio_reg;
        load_en    = clk_en_reg;
        done_next  = 1'b0;
        err_next   = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (accept) begin
                    if (req_illegal) begin
                        err_next = 1'b1;
                    end else if (req_same) begin
                        done_next = 1'b1;
                    end else if (!clk_en_reg) begin
                        // Stopped divider has no period to protect: apply straight from the request.
                        state_next = ST_APPLY;
                        load_cfg   = 1'b1;
                        load_ratio = i_cfg_ratio;
                        load_en    = i_cfg_en;
                        done_next  = 1'b1;
                    end else begin
                        state_next = ST_WAIT_BND;
                    end
                end
            end
            ST_WAIT_BND: begin
                if (tick_w) begin
                    state_next = ST_APPLY;
                    load_cfg   = 1'b1;
                    load_ratio = pend_ratio_reg;
                    load_en    = pend_en_reg;
                    done_next  = 1'b1;
                end
            end
            ST_APPLY: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_ref_clk) begin
        if (i_rst) begin
            state_reg      <= ST_IDLE;
            div_ratio_reg  <= RATIO_W'(DEF_RATIO);
            clk_en_reg     <= 1'b0;
            cnt_reg        <= '0;
            pend_ratio_reg <= '0;
            pend_en_reg    <= 1'b0;
            done_reg       <= 1'b0;
            err_reg        <= 1'b0;
        end else begin
            state_reg <= state_next;
            done_reg  <= done_next;
            err_reg   <= err_next;
            if (accept) begin
                pend_ratio_reg <= i_cfg_ratio;
                pend_en_reg    <= i_cfg_en;
            end
            if (load_cfg) begin
                div_ratio_reg <= load_ratio;
                clk_en_reg    <= load_en;
                cnt_reg       <= '0;
            end else if (!clk_en_reg || tick_w) begin
                cnt_reg <= '0;
            end else begin
                cnt_reg <= cnt_reg + RATIO_W'(1);
            end
        end
    end

    assign o_cfg_ready   = (state_reg == ST_IDLE);
    assign o_busy        = (state_reg != ST_IDLE);
    assign o_div_ratio   = div_ratio_reg;
    assign o_clk_en      = clk_en_reg;
    assign o_cfg_done    = done_reg;
    assign o_cfg_err     = err_reg;
    assign o_period_tick = tick_w;

endmodule

// File: tb/tb_clk_div_cfg_ctrl.sv
// Directed bench for clk_div_cfg_ctrl: reset, enable, boundary-aligned change, reject,
// reset during a pending change, and boundary-aligned disable.
module tb_clk_div_cfg_ctrl;

    logic       clk;
    logic       rst;
    logic       cfg_valid;
    logic [2:0] cfg_ratio;
    logic       cfg_en;
    logic       cfg_ready;
    logic [2:0] div_ratio;
    logic       clk_en;
    logic       cfg_done;
    logic       cfg_err;
    logic       busy;
    logic       period_tick;

    int checks_cnt = 0;
    int errors_cnt = 0;

    clk_div_cfg_ctrl #(
        .RATIO_W  (3),
        .DEF_RATIO(2),
        .MIN_RATIO(1)
    ) dut (
        .i_ref_clk    (clk),
        .i_rst        (rst),
        .i_cfg_valid  (cfg_valid),
        .i_cfg_ratio  (cfg_ratio),
        .i_cfg_en     (cfg_en),
        .o_cfg_ready  (cfg_ready),
        .o_div_ratio  (div_ratio),
        .o_clk_en     (clk_en),
        .o_cfg_done   (cfg_done),
        .o_cfg_err    (cfg_err),
        .o_busy       (busy),
        .o_period_tick(period_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_cnt++;
        if (obs !== exp) begin
            errors_cnt++;
            $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end else begin
            $display("ok   %s = %0d", tag, obs);
        end
    endtask

    // Advance one edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic request(input logic [2:0] r, input logic e);
        cfg_valid = 1'b1;
        cfg_ratio = r;
        cfg_en    = e;
    endtask

    initial begin
        rst = 1'b1; cfg_valid = 1'b0; cfg_ratio = 3'd0; cfg_en = 1'b0;

        // T1 reset
        step(); step();
        rst = 1'b0;
        check("t1_ratio", 32'(div_ratio), 2);
        check("t1_en", 32'(clk_en), 0);
        check("t1_ready", 32'(cfg_ready), 1);
        check("t1_busy", 32'(busy), 0);
        check("t1_tick", 32'(period_tick), 0);
        check("t1_done", 32'(cfg_done), 0);
        step(); step();
        check("t1_tick_idle", 32'(period_tick), 0);

        // T2 enable from idle: immediate apply, ticks every 4 cycles
        request(3'd4, 1'b1);
        step();
        cfg_valid = 1'b0;
        check("t2_ratio", 32'(div_ratio), 4);
        check("t2_en", 32'(clk_en), 1);
        check("t2_done", 32'(cfg_done), 1);
        check("t2_ready_apply", 32'(cfg_ready), 0);
        check("t2_tick_n1", 32'(period_tick), 0);
        step();
        check("t2_done_clr", 32'(cfg_done), 0);
        check("t2_ready_back", 32'(cfg_ready), 1);
        step();
        check("t2_tick_n3", 32'(period_tick), 0);
        step();
        check("t2_tick_n4", 32'(period_tick), 1);
        step();
        check("t2_tick_n5", 32'(period_tick), 0);
        step(); step(); step();
        check("t2_tick_n8", 32'(period_tick), 1);

        // T3 change 4->3 requested at cnt=1
        step(); step();
        request(3'd3, 1'b1);
        step();
        request(3'd7, 1'b1);          // must be ignored while busy
        check("t3_ready_wait", 32'(cfg_ready), 0);
        check("t3_busy_wait", 32'(busy), 1);
        check("t3_ratio_held", 32'(div_ratio), 4);
        check("t3_tick_cnt2", 32'(period_tick), 0);
        step();
        check("t3_tick_cnt3", 32'(period_tick), 1);
        check("t3_ratio_held2", 32'(div_ratio), 4);
        check("t3_done_early", 32'(cfg_done), 0);
        step();
        cfg_valid = 1'b0;
        check("t3_ratio_new", 32'(div_ratio), 3);
        check("t3_done", 32'(cfg_done), 1);
        check("t3_tick_apply", 32'(period_tick), 0);
        step();
        check("t3_done_clr", 32'(cfg_done), 0);
        check("t3_tick_c1", 32'(period_tick), 0);
        step();
        check("t3_tick_c2", 32'(period_tick), 1);
        check("t3_ratio_keep", 32'(div_ratio), 3);

        // T4 illegal ratio 0 (issued in a tick cycle, cnt wraps normally)
        request(3'd0, 1'b1);
        step();
        cfg_valid = 1'b0;
        check("t4_err", 32'(cfg_err), 1);
        check("t4_done", 32'(cfg_done), 0);
        check("t4_ratio", 32'(div_ratio), 3);
        check("t4_en", 32'(clk_en), 1);
        check("t4_ready", 32'(cfg_ready), 1);
        check("t4_tick_c0", 32'(period_tick), 0);
        step();
        check("t4_err_clr", 32'(cfg_err), 0);
        step();
        check("t4_tick_c2", 32'(period_tick), 1);

        // T5 go to ratio 5, then reset during WAIT_BND; tick in accept cycle does not count
        request(3'd5, 1'b1);
        step();
        cfg_valid = 1'b0;
        check("t5_busy", 32'(busy), 1);
        check("t5_ratio_held", 32'(div_ratio), 3);
        step(); step();
        check("t5_tick", 32'(period_tick), 1);
        step();
        check("t5_ratio5", 32'(div_ratio), 5);
        check("t5_done5", 32'(cfg_done), 1);
        step();
        request(3'd2, 1'b1);
        step();
        cfg_valid = 1'b0;
        check("t5_busy2", 32'(busy), 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("t5_rst_ratio", 32'(div_ratio), 2);
        check("t5_rst_en", 32'(clk_en), 0);
        check("t5_rst_busy", 32'(busy), 0);
        check("t5_rst_done", 32'(cfg_done), 0);
        step(); step();
        check("t5_no_apply_en", 32'(clk_en), 0);
        check("t5_no_done", 32'(cfg_done), 0);

        // T6 run at ratio 3, then disable on a boundary, then repeat the same request
        request(3'd3, 1'b1);
        step();
        cfg_valid = 1'b0;
        check("t6_en_on", 32'(clk_en), 1);
        step();
        request(3'd3, 1'b0);
        step();
        cfg_valid = 1'b0;
        check("t6_en_held", 32'(clk_en), 1);
        check("t6_tick_wait", 32'(period_tick), 1);
        step();
        check("t6_en_off", 32'(clk_en), 0);
        check("t6_done", 32'(cfg_done), 1);
        check("t6_tick_off", 32'(period_tick), 0);
        step();
        check("t6_tick_off2", 32'(period_tick), 0);
        check("t6_busy", 32'(busy), 0);
        request(3'd3, 1'b0);
        step();
        cfg_valid = 1'b0;
        check("t6_same_done", 32'(cfg_done), 1);
        check("t6_same_busy", 32'(busy), 0);
        check("t6_same_ready", 32'(cfg_ready), 1);
        step();
        check("t6_same_done_clr", 32'(cfg_done), 0);
        check("t6_tick_off3", 32'(period_tick), 0);

        $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
        $finish;
    end

endmodule
